vga_text_buffer: RTL and testbench
==================================

VGA_TEXT_BUFFER -- requirements
Module: vga_text_buffer

Interface
REQ-001 Parameter COLS, default 80: characters per row.
REQ-002 Parameter ROWS, default 30: rows per screen.
REQ-003 Parameter ATTR_W, default 8: attribute (colour) bits per cell.
REQ-004 Derived widths: CW = clog2(COLS), RW = clog2(ROWS); a cell is {attr[ATTR_W], char[8]}.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock; all state is updated on the rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 wr_valid  in  1  character stream valid.
REQ-009 wr_ready  out  1  character stream ready; a transfer occurs when wr_valid && wr_ready.
REQ-010 wr_char  in  8  character code or control code.
REQ-011 wr_attr  in  ATTR_W  attribute stored with a printable character.
REQ-012 clr_req  in  1  level request to clear the whole screen.
REQ-013 rd_col / rd_row  in  CW / RW  logical display coordinate to fetch.
REQ-014 rd_char / rd_attr  out  8 / ATTR_W  registered cell contents.
REQ-015 cur_col / cur_row  out  CW / RW  cursor position (logical).
REQ-016 scroll_base  out  RW  physical row currently displayed as logical row 0.
REQ-017 busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-018 Storage: COLS*ROWS cells in inferred dual-port RAM, one synchronous write port and one synchronous read port; physical index = prow*COLS + col.
REQ-019 Read path: prow = (rd_row + scroll_base) mod ROWS; rd_char/rd_attr are valid exactly 1 cycle after the coordinates are presented; reads are allowed in every state.
REQ-020 Read out of range (rd_col >= COLS or rd_row >= ROWS): the block returns rd_char = 0x20 and rd_attr = 0, with the same 1-cycle latency.
REQ-021 Read and write to the same cell in the same cycle: the read returns the old data.
REQ-022 FSM states: CLEAR, IDLE, SCROLL_CLR.
REQ-023 wr_ready = (state == IDLE) && !clr_req, combinational.
REQ-024 clr_req is sampled only in IDLE and wins over a simultaneous wr_valid; that character is not accepted.
REQ-025 CLEAR: writes blank (0x20, attr 0) to physical indices 0 .. COLS*ROWS-1, one per cycle, for COLS*ROWS cycles; on the last write it sets cur_col=0, cur_row=0, scroll_base=0 and goes to IDLE.
REQ-026 Accepted 0x0A (LF): cur_col <- 0, then row-advance.
REQ-027 Accepted 0x0D (CR): cur_col <- 0; no RAM write.
REQ-028 Accepted 0x08 (BS): if cur_col > 0 then cur_col - 1; no-op at column 0; no RAM write.
REQ-029 Any other accepted code: write {wr_attr, wr_char} at (cur_row, cur_col) translated by scroll_base; then cur_col + 1, except at cur_col == COLS-1, where cur_col <- 0 and row-advance.
REQ-030 Row-advance when cur_row < ROWS-1: cur_row + 1; state stays IDLE.
REQ-031 Row-advance when cur_row == ROWS-1: cur_row is held; scroll_base <- (scroll_base+1) mod ROWS; enter SCROLL_CLR.
REQ-032 SCROLL_CLR: blanks the COLS cells of the physical row equal to the old scroll_base (the new bottom row), one per cycle, for COLS cycles, then returns to IDLE.
REQ-033 All arithmetic on cursor and scroll_base is modulo COLS/ROWS; the registers never hold an out-of-range value.

Reset
REQ-034 On rst_n low: state <- CLEAR with clear counter 0; cur_col = cur_row = scroll_base = 0; rd_char = 0x20; rd_attr = 0; busy = 1; wr_ready = 0.
REQ-035 After rst_n release, a full CLEAR runs (COLS*ROWS cycles) before the first transfer can be accepted.
REQ-036 Reset asserted mid-CLEAR or mid-SCROLL_CLR aborts the operation and restarts CLEAR from index 0.

Verification
REQ-037 Release reset -> busy=1 for 2400 cycles, then wr_ready=1; reads of (0,0), (29,79) and (31,90) all return 0x20/0.
REQ-038 Send 'A','B' with attr 0x1F -> rd (0,0) = 0x41/0x1F and (0,1) = 0x42/0x1F one cycle after presentation; cur_col=2.
REQ-039 Send 80 printable characters -> cur_col=0, cur_row=1; the 81st lands at (1,0); BS at (1,0) leaves cur_col=0.
REQ-040 Send 29 LFs, then fill row 29, then one more LF -> scroll_base=1, busy for 80 cycles, logical row 29 blank, logical row 0 shows old physical row 1, cur_row=29.
REQ-041 Assert clr_req and wr_valid in the same cycle -> character not accepted, busy for 2400 cycles, then cursor (0,0) and scroll_base 0.
REQ-042 Pulse rst_n low 10 cycles into SCROLL_CLR -> scroll_base=0 and a full 2400-cycle CLEAR is restarted.

Source files
------------

// File: rtl/vga_text_buffer.sv
// Character-cell text buffer: a scrolling terminal-style writer in front of a dual-port cell RAM.
// Latency: rd_char/rd_attr are registered, 1 cycle after rd_col/rd_row; writes land 1 cycle after acceptance.
// Backpressure: wr_ready drops while the screen clear or row clear runs, and whenever clr_req is high.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   wr_valid/wr_ready       character stream handshake; wr_char, wr_attr carry the payload
//   clr_req                 level request to blank the whole screen (sampled only when idle)
//   rd_col/rd_row           logical coordinate to fetch; rd_char/rd_attr registered result
//   cur_col/cur_row         logical cursor position
//   scroll_base             physical row shown as logical row 0
//   busy                    high while a clear or row clear is in progress
module vga_text_buffer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ATTR_W = 8,
  localparam int CW    = $clog2(COLS),
  localparam int RW    = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [7:0]        wr_char,
  input  logic [ATTR_W-1:0] wr_attr,
  input  logic              clr_req,
  input  logic [CW-1:0]     rd_col,
  input  logic [RW-1:0]     rd_row,
  output logic [7:0]        rd_char,
  output logic [ATTR_W-1:0] rd_attr,
  output logic [CW-1:0]     cur_col,
  output logic [RW-1:0]     cur_row,
  output logic [RW-1:0]     scroll_base,
  output logic              busy
);

  localparam int CELLS = COLS * ROWS;
  localparam int IW    = $clog2(CELLS);
  localparam int DW    = ATTR_W + 8;

  localparam logic [IW-1:0] COLS_I    = IW'(COLS);
  localparam logic [IW-1:0] LAST_IDX  = IW'(CELLS - 1);
  localparam logic [IW-1:0] ROW_LAST  = IW'(COLS - 1);
  localparam logic [CW-1:0] COLS_M1   = CW'(COLS - 1);
  localparam logic [RW-1:0] ROWS_M1   = RW'(ROWS - 1);
  localparam logic [RW:0]   ROWS_X    = (RW+1)'(ROWS);
  localparam logic [CW:0]   COLS_X    = (CW+1)'(COLS);
  localparam logic [DW-1:0] BLANK     = {{ATTR_W{1'b0}}, 8'h20};

  typedef enum logic [1:0] {CLEAR, IDLE, SCROLL_CLR} state_t;

  state_t          state;
  logic [IW-1:0]   cnt;
  logic [RW-1:0]   clr_row;

  logic [DW-1:0]   mem [CELLS];

  logic            wr_fire;
  logic            is_print;
  logic            advance;
  logic            wr_en;
  logic [IW-1:0]   wr_idx;
  logic [DW-1:0]   wr_dat;
  logic            rd_oor;
  logic [IW-1:0]   rd_idx;

  // Logical row -> physical row: add scroll_base and wrap once.
  function automatic logic [RW-1:0] wrap_row(input logic [RW-1:0] a, input logic [RW-1:0] b);
    logic [RW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= ROWS_X) s = s - ROWS_X;
    return s[RW-1:0];
  endfunction

  function automatic logic [IW-1:0] cell_idx(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return IW'(r) * COLS_I + IW'(c);
  endfunction

  assign wr_ready = (state == IDLE) && !clr_req;
  assign busy     = (state != IDLE);
  assign wr_fire  = wr_valid && wr_ready;
  assign is_print = (wr_char != 8'h0A) && (wr_char != 8'h0D) && (wr_char != 8'h08);
  assign advance  = wr_fire && ((wr_char == 8'h0A) || (is_print && cur_col == COLS_M1));

  // Single write port shared by screen clear, row clear and character writes.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = '0;
    wr_dat = BLANK;
    case (state)
      CLEAR: begin
        wr_en  = 1'b1;
        wr_idx = cnt;
      end
      SCROLL_CLR: begin
        wr_en  = 1'b1;
        wr_idx = cell_idx(clr_row, cnt[CW-1:0]);
      end
      IDLE: begin
        if (wr_fire && is_print) begin
          wr_en  = 1'b1;
          wr_idx = cell_idx(wrap_row(cur_row, scroll_base), cur_col);
          wr_dat = {wr_attr, wr_char};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_dat;
  end

  // Out-of-range coordinates read as a blank; the index is forced to 0 so the
  // RAM is never addressed past its end.
  assign rd_oor = ({1'b0, rd_col} >= COLS_X) || ({1'b0, rd_row} >= ROWS_X);
  assign rd_idx = rd_oor ? '0 : cell_idx(wrap_row(rd_row, scroll_base), rd_col);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {rd_attr, rd_char} <= BLANK;
    end else if (rd_oor) begin
      {rd_attr, rd_char} <= BLANK;
    end else begin
      {rd_attr, rd_char} <= mem[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CLEAR;
      cnt         <= '0;
      clr_row     <= '0;
      cur_col     <= '0;
      cur_row     <= '0;
      scroll_base <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (cnt == LAST_IDX) begin
            cnt         <= '0;
            cur_col     <= '0;
            cur_row     <= '0;
            scroll_base <= '0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SCROLL_CLR: begin
          if (cnt == ROW_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (clr_req) begin
            cnt   <= '0;
            state <= CLEAR;
          end else if (wr_valid) begin
            case (wr_char)
              8'h0A, 8'h0D: cur_col <= '0;
              8'h08: if (cur_col != '0) cur_col <= cur_col - 1'b1;
              default: cur_col <= (cur_col == COLS_M1) ? '0 : cur_col + 1'b1;
            endcase
            // At the bottom row the cursor stays put and the screen scrolls:
            // the old top physical row becomes the new bottom and is blanked.
            if (advance) begin
              if (cur_row != ROWS_M1) begin
                cur_row <= cur_row + 1'b1;
              end else begin
                scroll_base <= (scroll_base == ROWS_M1) ? '0 : scroll_base + 1'b1;
                clr_row     <= scroll_base;
                cnt         <= '0;
                state       <= SCROLL_CLR;
              end
            end
          end
        end
        default: begin
          cnt   <= '0;
          state <= CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_text_buffer.sv
module tb_vga_text_buffer;
  localparam int COLS = 80;
  localparam int ROWS = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_char = 8'h00;
  logic [7:0] wr_attr = 8'h00;
  logic       clr_req = 1'b0;
  logic [6:0] rd_col = '0;
  logic [4:0] rd_row = '0;
  logic [7:0] rd_char;
  logic [7:0] rd_attr;
  logic [6:0] cur_col;
  logic [4:0] cur_row;
  logic [4:0] scroll_base;
  logic       busy;

  vga_text_buffer #(.COLS(COLS), .ROWS(ROWS), .ATTR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_char(wr_char), .wr_attr(wr_attr),
    .clr_req(clr_req), .rd_col(rd_col), .rd_row(rd_row),
    .rd_char(rd_char), .rd_attr(rd_attr),
    .cur_col(cur_col), .cur_row(cur_row), .scroll_base(scroll_base), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: the screen as the viewer sees it (logical rows). Scrolling moves
  // rows up and blanks the bottom; the scroll base is just a wrapping counter.
  logic [15:0] scr [ROWS][COLS];
  int m_col, m_row, m_sb;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = 16'h0020;
    m_col = 0; m_row = 0; m_sb = 0;
  endtask

  task automatic model_newline();
    if (m_row < ROWS - 1) begin
      m_row++;
    end else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 16'h0020;
      m_sb = (m_sb + 1) % ROWS;
    end
  endtask

  task automatic model_apply(input logic [7:0] ch, input logic [7:0] at);
    if (ch == 8'h0A) begin
      m_col = 0; model_newline();
    end else if (ch == 8'h0D) begin
      m_col = 0;
    end else if (ch == 8'h08) begin
      if (m_col > 0) m_col--;
    end else begin
      scr[m_row][m_col] = {at, ch};
      if (m_col == COLS - 1) begin
        m_col = 0; model_newline();
      end else begin
        m_col++;
      end
    end
  endtask

  function automatic logic [15:0] model_read(input int r, input int c);
    if (r >= ROWS || c >= COLS) return 16'h0020;
    return scr[r][c];
  endfunction

  // Compare process: the expected read is captured at the edge that samples
  // the coordinates (before that edge's model update), checked at the next negedge.
  logic [15:0] exp_rd;
  bit exp_vld = 1'b0;
  always @(posedge clk) begin
    exp_vld = rst_n && !busy;
    exp_rd  = model_read(int'(rd_row), int'(rd_col));
  end

  always @(negedge clk) begin
    if (chk_en && exp_vld) begin
      check("cmp_rd_char", rd_char, exp_rd[7:0]);
      check("cmp_rd_attr", rd_attr, exp_rd[15:8]);
    end
    if (chk_en && rst_n && !busy) begin
      check("cmp_cur_col", cur_col, m_col);
      check("cmp_cur_row", cur_row, m_row);
      check("cmp_scroll_base", scroll_base, m_sb);
    end
  end

  task automatic send(input logic [7:0] ch, input logic [7:0] at);
    int n;
    n = 0;
    @(negedge clk);
    while (!wr_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!wr_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: wr_ready still 0 after %0d cycles, required 1", n);
      return;
    end
    wr_valid = 1'b1; wr_char = ch; wr_attr = at;
    @(posedge clk);
    #1;
    model_apply(ch, at);
    wr_valid = 1'b0;
  endtask

  // Called at a negedge; counts negedges with busy high.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic rd_expect(input int r, input int c, input int ec, input int ea, input string name);
    @(negedge clk);
    rd_row = 5'(r); rd_col = 7'(c);
    @(negedge clk);
    check({name, ".char"}, rd_char, ec);
    check({name, ".attr"}, rd_attr, ea);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_char", rd_char, 8'h20);
    check("rst_rd_attr", rd_attr, 0);
    check("rst_cur_col", cur_col, 0);
    check("rst_cur_row", cur_row, 0);
    check("rst_scroll_base", scroll_base, 0);

    // Full clear after reset release
    rst_n = 1'b1;
    count_busy(n);
    check("clear_cycles", n, 2400);
    check("ready_after_clear", wr_ready, 1);
    chk_en = 1'b1;
    rd_expect(0, 0, 8'h20, 0, "blank_0_0");
    rd_expect(29, 79, 8'h20, 0, "blank_29_79");
    rd_expect(31, 90, 8'h20, 0, "oor_31_90");

    // Two printable characters
    send(8'h41, 8'h1F);
    send(8'h42, 8'h1F);
    rd_expect(0, 0, 8'h41, 8'h1F, "char_A");
    rd_expect(0, 1, 8'h42, 8'h1F, "char_B");
    check("col_after_AB", cur_col, 2);

    // CR then a full row wraps onto the next row
    send(8'h0D, 8'h00);
    for (int i = 0; i < 80; i++) send(8'(8'h21 + i), 8'h07);
    check("wrap_col", cur_col, 0);
    check("wrap_row", cur_row, 1);
    rd_expect(0, 0, 8'h21, 8'h07, "row0_first");
    rd_expect(0, 79, 8'h70, 8'h07, "row0_last");
    send(8'h5A, 8'h07);
    rd_expect(1, 0, 8'h5A, 8'h07, "char_81");
    send(8'h08, 8'h00);
    check("bs_col", cur_col, 0);
    send(8'h08, 8'h00);
    check("bs_at_col0", cur_col, 0);
    check("bs_row", cur_row, 1);

    // Down to the bottom row, fill it up to col 78, then LF scrolls
    while (m_row < ROWS - 1) send(8'h0A, 8'h00);
    check("bottom_row", cur_row, 29);
    for (int i = 0; i < 79; i++) send(8'(8'h61 + i % 26), 8'h4E);
    check("bottom_col", cur_col, 79);
    send(8'h0A, 8'h00);
    @(negedge clk);
    count_busy(n);
    check("scroll_cycles", n, 80);
    check("scroll_base_1", scroll_base, 1);
    check("scroll_cur_row", cur_row, 29);
    rd_expect(0, 0, 8'h5A, 8'h07, "scrolled_row0_c0");
    rd_expect(0, 1, 8'h20, 0, "scrolled_row0_c1");
    rd_expect(28, 0, 8'h61, 8'h4E, "scrolled_row28_c0");
    rd_expect(28, 79, 8'h20, 0, "scrolled_row28_c79");
    rd_expect(29, 0, 8'h20, 0, "new_bottom_c0");
    rd_expect(29, 78, 8'h20, 0, "new_bottom_c78");
    for (int c = 0; c < COLS; c++) begin
      @(negedge clk);
      rd_row = 5'd29; rd_col = 7'(c);
    end
    @(negedge clk);

    // clr_req wins over a simultaneous character
    @(negedge clk);
    clr_req = 1'b1; wr_valid = 1'b1; wr_char = 8'h51; wr_attr = 8'h33;
    rd_row = 5'd0; rd_col = 7'd0;
    #1;
    check("clr_blocks_ready", wr_ready, 0);
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    clr_req = 1'b0; wr_valid = 1'b0;
    count_busy(n);
    check("clr_cycles", n, 2400);
    check("clr_cur_col", cur_col, 0);
    check("clr_cur_row", cur_row, 0);
    check("clr_scroll_base", scroll_base, 0);
    rd_expect(0, 0, 8'h20, 0, "clr_not_written");

    // Reset in the middle of a row clear restarts the full clear
    while (m_row < ROWS - 1) send(8'h0A, 8'h00);
    send(8'h0A, 8'h00);
    repeat (10) @(negedge clk);
    check("mid_scroll_busy", busy, 1);
    check("mid_scroll_base", scroll_base, 1);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check("mid_rst_scroll_base", scroll_base, 0);
    check("mid_rst_busy", busy, 1);
    check("mid_rst_ready", wr_ready, 0);
    check("mid_rst_cur_row", cur_row, 0);
    repeat (9) @(negedge clk);
    rst_n = 1'b1;
    count_busy(n);
    check("restart_clear_cycles", n, 2400);
    check("restart_scroll_base", scroll_base, 0);
    rd_expect(29, 0, 8'h20, 0, "restart_blank");
    send(8'h43, 8'h05);
    rd_expect(0, 0, 8'h43, 8'h05, "after_restart_write");

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
